// File: rtl/uart_frame_rx_if.sv
// Byte-stream input, memory-write output and frame status of the UART frame receiver.
// The receiver uses the slave modport; whatever feeds bytes and accepts writes uses master.
interface uart_frame_rx_if #(
    parameter int BITWIDTH = 32
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                mem_wr_en;
    logic                mem_wr_sel;
    logic [BITWIDTH-1:0] mem_wr_addr;
    logic [BITWIDTH-1:0] mem_wr_data;
    logic                mem_wr_ready;
    logic                frame_done;
    logic                frame_error;
    logic                busy;

    modport slave (
        input  rx_data, rx_valid, mem_wr_ready,
        output rx_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
               frame_done, frame_error, busy
    );

    modport master (
        output rx_data, rx_valid, mem_wr_ready,
        input  rx_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
               frame_done, frame_error, busy
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Decodes length-prefixed UART frames (count, header, payload) into word writes
// to instruction or block memory, with idle timeout and error reporting.
module uart_frame_rx #(
    parameter int BITWIDTH  = 32,
    parameter int MAX_BYTES = 1025,
    parameter int TIMEOUT   = 65535
) (
    input  logic          clock,
    input  logic          reset,
    uart_frame_rx_if.slave bus
);
    typedef enum logic [2:0] {
        S_COUNT, S_HEADER, S_DATA, S_WRITE, S_DRAIN, S_END
    } state_t;

    localparam int          WORD_BYTES = BITWIDTH / 8;
    localparam logic [31:0] MAX_W      = 32'(MAX_BYTES);
    localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT);

    state_t              state_reg;
    logic [31:0]         count_reg;
    logic [31:0]         remain_reg;
    logic [31:0]         idle_reg;
    logic [1:0]          count_idx_reg;
    logic [7:0]          byte_idx_reg;
    logic                err_reg;
    logic [BITWIDTH-1:0] addr_reg;
    logic                sel_reg;
    logic                rx_ready_reg;
    logic                mem_wr_en_reg;
    logic                done_reg;
    logic                ferr_reg;
    logic                busy_reg;
    logic [BITWIDTH-1:0] word;

    logic        accept;
    logic        lane_wr;
    logic        timeout_hit;
    logic [31:0] count_full;

    assign accept      = bus.rx_valid && rx_ready_reg;
    assign lane_wr     = accept && (state_reg == S_DATA);
    assign count_full  = {bus.rx_data, count_reg[31:8]};
    // rx_ready_reg is high exactly in the byte-accepting states, which are the only ones that can time out
    assign timeout_hit = busy_reg && rx_ready_reg && !accept && (idle_reg == TIMEOUT_W - 32'd1);

    // One byte lane per word byte; the word stays frozen while S_WRITE holds rx_ready low
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clock) begin
                if (!reset) begin
                    lane_reg <= '0;
                end else if (lane_wr && (byte_idx_reg == 8'(gi))) begin
                    lane_reg <= bus.rx_data;
                end
            end
            assign word[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_COUNT;
            count_reg     <= '0;
            remain_reg    <= '0;
            idle_reg      <= '0;
            count_idx_reg <= '0;
            byte_idx_reg  <= '0;
            err_reg       <= 1'b0;
            addr_reg      <= '0;
            sel_reg       <= 1'b0;
            rx_ready_reg  <= 1'b1;
            mem_wr_en_reg <= 1'b0;
            done_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            ferr_reg <= 1'b0;
            if (accept || state_reg == S_WRITE) begin
                idle_reg <= '0;
            end else if (busy_reg) begin
                idle_reg <= idle_reg + 32'd1;
            end

            if (timeout_hit) begin
                err_reg      <= 1'b1;
                state_reg    <= S_END;
                rx_ready_reg <= 1'b0;
                done_reg     <= 1'b1;
                ferr_reg     <= 1'b1;
            end else begin
                unique case (state_reg)
                    S_COUNT: begin
                        if (accept) begin
                            count_reg     <= count_full;
                            count_idx_reg <= count_idx_reg + 2'd1;
                            busy_reg      <= 1'b1;
                            if (count_idx_reg == 2'd3) begin
                                if (count_full == 32'd0 || count_full > MAX_W) begin
                                    err_reg    <= 1'b1;
                                    remain_reg <= count_full;
                                    state_reg  <= S_DRAIN;
                                end else begin
                                    state_reg <= S_HEADER;
                                end
                            end
                        end
                    end
                    S_HEADER: begin
                        if (accept) begin
                            sel_reg      <= bus.rx_data[7];
                            addr_reg     <= BITWIDTH'({bus.rx_data[6:0], 8'h00});
                            remain_reg   <= count_reg - 32'd1;
                            byte_idx_reg <= '0;
                            if (count_reg == 32'd1) begin
                                state_reg    <= S_END;
                                rx_ready_reg <= 1'b0;
                                done_reg     <= 1'b1;
                                ferr_reg     <= err_reg;
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            remain_reg <= remain_reg - 32'd1;
                            if (byte_idx_reg == 8'(WORD_BYTES - 1)) begin
                                byte_idx_reg  <= '0;
                                state_reg     <= S_WRITE;
                                mem_wr_en_reg <= 1'b1;
                                rx_ready_reg  <= 1'b0;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 8'd1;
                                // Payload ran out mid-word: the partial word is never written
                                if (remain_reg == 32'd1) begin
                                    err_reg      <= 1'b1;
                                    state_reg    <= S_END;
                                    rx_ready_reg <= 1'b0;
                                    done_reg     <= 1'b1;
                                    ferr_reg     <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (bus.mem_wr_ready) begin
                            mem_wr_en_reg <= 1'b0;
                            addr_reg      <= addr_reg + (sel_reg ? BITWIDTH'(1) : BITWIDTH'(4));
                            if (remain_reg == 32'd0) begin
                                state_reg <= S_END;
                                done_reg  <= 1'b1;
                                ferr_reg  <= err_reg;
                            end else begin
                                state_reg    <= S_DATA;
                                rx_ready_reg <= 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (remain_reg == 32'd0 || (accept && remain_reg == 32'd1)) begin
                            remain_reg   <= '0;
                            state_reg    <= S_END;
                            rx_ready_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            ferr_reg     <= err_reg;
                        end else if (accept) begin
                            remain_reg <= remain_reg - 32'd1;
                        end
                    end
                    S_END: begin
                        state_reg     <= S_COUNT;
                        count_reg     <= '0;
                        count_idx_reg <= '0;
                        remain_reg    <= '0;
                        byte_idx_reg  <= '0;
                        idle_reg      <= '0;
                        err_reg       <= 1'b0;
                        rx_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                    default: begin
                        state_reg    <= S_COUNT;
                        rx_ready_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready    = rx_ready_reg;
    assign bus.mem_wr_en   = mem_wr_en_reg;
    assign bus.mem_wr_sel  = sel_reg;
    assign bus.mem_wr_addr = addr_reg;
    assign bus.mem_wr_data = word;
    assign bus.frame_done  = done_reg;
    assign bus.frame_error = ferr_reg;
    assign bus.busy        = busy_reg;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: frames driven byte by byte, writes and
// done/error pulses captured by monitors and compared with hand-computed values.
module tb_uart_frame_rx;
    localparam int BW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_frame_rx_if #(.BITWIDTH(BW)) bus ();

    uart_frame_rx #(
        .BITWIDTH (BW),
        .MAX_BYTES(1025),
        .TIMEOUT  (40)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Write log {sel, addr, data} and frame status counters
    logic [64:0] wq[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int lone_err = 0;

    always @(posedge clock) begin
        if (bus.mem_wr_en && bus.mem_wr_ready) wq.push_back({bus.mem_wr_sel, bus.mem_wr_addr, bus.mem_wr_data});
        if (bus.frame_done) done_cnt++;
        if (bus.frame_error) err_cnt++;
        if (bus.frame_error && !bus.frame_done) lone_err++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("rx_ready_wait", 96'(n), 96'(0));
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int prev = done_cnt;
        int n = 0;
        while (done_cnt == prev && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 96'(done_cnt != prev), 96'(1));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctl"}, 96'({bus.rx_ready, bus.mem_wr_en, bus.mem_wr_sel,
                                bus.frame_done, bus.frame_error, bus.busy}), 96'(6'b100000));
        chk({tag, "_addr"}, 96'(bus.mem_wr_addr), 96'(0));
        chk({tag, "_data"}, 96'(bus.mem_wr_data), 96'(0));
    endtask

    task automatic frame_a(input string tag);
        int d0 = done_cnt;
        int e0 = err_cnt;
        wq.delete();
        send_word(32'd9, 4);
        send_byte(8'h83);
        send_word(32'h04030201, 4);
        send_word(32'hDDCCBBAA, 4);
        wait_done({tag, "_done"}, 50);
        chk({tag, "_nwr"}, 96'(wq.size()), 96'(2));
        if (wq.size() == 2) begin
            chk({tag, "_wr0"}, 96'(wq[0]), 96'({1'b1, 32'h300, 32'h04030201}));
            chk({tag, "_wr1"}, 96'(wq[1]), 96'({1'b1, 32'h301, 32'hDDCCBBAA}));
        end
        chk({tag, "_dcnt"}, 96'(done_cnt - d0), 96'(1));
        chk({tag, "_ecnt"}, 96'(err_cnt - e0), 96'(0));
        chk({tag, "_idle"}, 96'({bus.busy, bus.rx_ready}), 96'(2'b01));
    endtask

    initial begin
        int d0;
        int e0;
        bus.rx_data      = 8'h00;
        bus.rx_valid     = 1'b0;
        bus.mem_wr_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check_reset_outs("reset");
        reset = 1'b1;
        @(negedge clock);

        // Two bmem writes at block 3
        frame_a("frameA");

        // imem write stalled for 5 cycles
        d0 = done_cnt; e0 = err_cnt; wq.delete();
        bus.mem_wr_ready = 1'b0;
        send_word(32'd5, 4);
        send_byte(8'h02);
        send_word(32'h40302010, 4);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ctl", 96'({bus.mem_wr_en, bus.mem_wr_sel, bus.rx_ready}), 96'(3'b100));
            chk("stall_addr", 96'(bus.mem_wr_addr), 96'(32'h200));
            chk("stall_data", 96'(bus.mem_wr_data), 96'(32'h40302010));
            @(negedge clock);
        end
        bus.mem_wr_ready = 1'b1;
        wait_done("stall_done", 50);
        chk("stall_nwr", 96'(wq.size()), 96'(1));
        if (wq.size() == 1) chk("stall_wr0", 96'(wq[0]), 96'({1'b0, 32'h200, 32'h40302010}));
        chk("stall_ecnt", 96'(err_cnt - e0), 96'(0));

        // Header-only frame
        d0 = done_cnt; e0 = err_cnt; wq.delete();
        send_word(32'd1, 4);
        send_byte(8'h7F);
        wait_done("hdr_done", 50);
        chk("hdr_nwr", 96'(wq.size()), 96'(0));
        chk("hdr_ecnt", 96'(err_cnt - e0), 96'(0));

        // Partial trailing word
        d0 = done_cnt; e0 = err_cnt; wq.delete();
        send_word(32'd4, 4);
        send_byte(8'h81);
        send_word(32'h00332211, 3);
        wait_done("part_done", 50);
        chk("part_nwr", 96'(wq.size()), 96'(0));
        chk("part_ecnt", 96'(err_cnt - e0), 96'(1));
        chk("part_lone", 96'(lone_err), 96'(0));

        // Oversized count drained, then idle timeout
        d0 = done_cnt; e0 = err_cnt; wq.delete();
        send_word(32'h0000FFFF, 4);
        for (int i = 0; i < 20; i++) send_byte(8'h55);
        wait_done("tmo_done", 200);
        chk("tmo_nwr", 96'(wq.size()), 96'(0));
        chk("tmo_ecnt", 96'(err_cnt - e0), 96'(1));
        frame_a("after_tmo");

        // Reset during the 3rd payload byte
        d0 = done_cnt; wq.delete();
        send_word(32'd9, 4);
        send_byte(8'h83);
        send_byte(8'h01);
        send_byte(8'h02);
        bus.rx_data  = 8'h03;
        bus.rx_valid = 1'b1;
        reset        = 1'b0;
        @(negedge clock);
        check_reset_outs("midrst");
        bus.rx_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clock);
        chk("midrst_nwr", 96'(wq.size()), 96'(0));
        chk("midrst_dcnt", 96'(done_cnt - d0), 96'(0));
        frame_a("after_midrst");

        // Reset while a write is stalled
        d0 = done_cnt; wq.delete();
        bus.mem_wr_ready = 1'b0;
        send_word(32'd5, 4);
        send_byte(8'h02);
        send_word(32'h40302010, 4);
        @(negedge clock);
        chk("wrrst_pre", 96'(bus.mem_wr_en), 96'(1));
        reset = 1'b0;
        @(negedge clock);
        check_reset_outs("wrrst");
        bus.mem_wr_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("wrrst_nwr", 96'(wq.size()), 96'(0));
        chk("wrrst_dcnt", 96'(done_cnt - d0), 96'(0));
        frame_a("after_wrrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
